// File: rtl/core_pkg.sv
// core_pkg
// Shared definitions for the five-stage MIPS core. The decoder, the ID/EX
// register, the forwarding unit and the EX stage all use this package.
// Contents:
//   CTRL_W        width of the decoded control bundle
//   CTRL_*        bit positions inside the control bundle
//   ctrl_t        packed control bundle type
//   aluOp_e       encoding of the two-bit ALUOp field
//   isLoad()      true when a control bundle describes a memory read
package core_pkg;

  localparam int CTRL_REGW      = 0;
  localparam int CTRL_MEMR      = 1;
  localparam int CTRL_MEMW      = 2;
  localparam int CTRL_MEM2REG   = 3;
  localparam int CTRL_ALUSRC    = 4;
  localparam int CTRL_ALUOP_LSB = 5;
  localparam int CTRL_ALUOP_W   = 2;
  localparam int CTRL_W         = CTRL_ALUOP_LSB + CTRL_ALUOP_W;

  typedef logic [CTRL_W-1:0] ctrl_t;

  typedef enum logic [CTRL_ALUOP_W-1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_LOGIC = 2'b11
  } aluOp_e;

  function automatic logic isLoad(input ctrl_t ctrl);
    return ctrl[CTRL_MEMR];
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// load_use_detect
// Purely combinational load-use hazard check. Flags the case where the
// instruction in EX is a valid load and its destination (Rt) is read by the
// instruction currently in ID.
// Ports:
//   exValid_i  EX slot holds a real instruction (not a bubble)
//   exCtrl_i   control bundle of the EX instruction
//   exRt_i     Rt (load destination) of the EX instruction
//   idRs_i     Rs of the ID instruction
//   idRt_i     Rt of the ID instruction
//   lu_o       load-use hazard present
module load_use_detect
  import core_pkg::*;
(
  input  logic       exValid_i,
  input  ctrl_t      exCtrl_i,
  input  logic [4:0] exRt_i,
  input  logic [4:0] idRs_i,
  input  logic [4:0] idRt_i,
  output logic       lu_o
);

  logic rtMatch;

  // $zero is never a real dependency, so a load targeting r0 cannot stall.
  assign rtMatch = (exRt_i != 5'd0) && ((exRt_i == idRs_i) || (exRt_i == idRt_i));
  assign lu_o    = exValid_i && isLoad(exCtrl_i) && rtMatch;

endmodule

// File: rtl/id_ex_hazard_reg.sv
// id_ex_hazard_reg
// ID/EX pipeline register with integrated load-use hazard detection.
// Captures the decoded ID instruction each enabled edge, inserts a one-cycle
// bubble for a load-use dependency or a squash, and counts hazard bubbles.
// Ports:
//   clk, rst_n                     core clock, async active-low reset
//   Stall                          global hold, freezes all state
//   Flush                          squash the instruction in ID
//   IfIdRs, IfIdRt, IdRd           register numbers of the ID instruction
//   IdCtrl                         decoded control bundle
//   IdRsData, IdRtData, IdImm      operands of the ID instruction
//   IdExRs, IdExRt, IdExRd         registered register numbers
//   IdExCtrl                       registered control bundle
//   IdExRsData, IdExRtData, IdExImm registered operands
//   IdExValid                      1 = real instruction, 0 = bubble
//   HazardStall                    combinational, hold PC and IF/ID
//   BubbleCnt                      saturating count of load-use bubbles
module id_ex_hazard_reg
  import core_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Stall,
  input  logic              Flush,
  input  logic [4:0]        IfIdRs,
  input  logic [4:0]        IfIdRt,
  input  logic [4:0]        IdRd,
  input  logic [CTRL_W-1:0] IdCtrl,
  input  logic [DATA_W-1:0] IdRsData,
  input  logic [DATA_W-1:0] IdRtData,
  input  logic [DATA_W-1:0] IdImm,
  output logic [4:0]        IdExRs,
  output logic [4:0]        IdExRt,
  output logic [4:0]        IdExRd,
  output logic [CTRL_W-1:0] IdExCtrl,
  output logic [DATA_W-1:0] IdExRsData,
  output logic [DATA_W-1:0] IdExRtData,
  output logic [DATA_W-1:0] IdExImm,
  output logic              IdExValid,
  output logic              HazardStall,
  output logic [CNT_W-1:0]  BubbleCnt
);

  logic [4:0]        exRs_q, exRs_d;
  logic [4:0]        exRt_q, exRt_d;
  logic [4:0]        exRd_q, exRd_d;
  ctrl_t             exCtrl_q, exCtrl_d;
  logic [DATA_W-1:0] exRsData_q, exRsData_d;
  logic [DATA_W-1:0] exRtData_q, exRtData_d;
  logic [DATA_W-1:0] exImm_q, exImm_d;
  logic              exValid_q, exValid_d;
  logic [CNT_W-1:0]  bubbleCnt_q, bubbleCnt_d;
  logic              lu;

  load_use_detect uLoadUse (
    .exValid_i (exValid_q),
    .exCtrl_i  (exCtrl_q),
    .exRt_i    (exRt_q),
    .idRs_i    (IfIdRs),
    .idRt_i    (IfIdRt),
    .lu_o      (lu)
  );

  // A squashed instruction is discarded anyway, so it must never freeze the
  // front end. Stall deliberately does not mask this output.
  assign HazardStall = lu && !Flush;

  always_comb begin
    exRs_d      = exRs_q;
    exRt_d      = exRt_q;
    exRd_d      = exRd_q;
    exCtrl_d    = exCtrl_q;
    exRsData_d  = exRsData_q;
    exRtData_d  = exRtData_q;
    exImm_d     = exImm_q;
    exValid_d   = exValid_q;
    bubbleCnt_d = bubbleCnt_q;

    if (!Stall) begin
      if (Flush || HazardStall) begin
        // Zeroed register numbers keep the forwarding unit from matching
        // against the bubble.
        exRs_d     = '0;
        exRt_d     = '0;
        exRd_d     = '0;
        exCtrl_d   = '0;
        exRsData_d = '0;
        exRtData_d = '0;
        exImm_d    = '0;
        exValid_d  = 1'b0;
        // Only hazard bubbles are counted, and the counter saturates.
        if (HazardStall && (bubbleCnt_q != {CNT_W{1'b1}})) begin
          bubbleCnt_d = bubbleCnt_q + CNT_W'(1);
        end
      end else begin
        exRs_d     = IfIdRs;
        exRt_d     = IfIdRt;
        exRd_d     = IdRd;
        exCtrl_d   = IdCtrl;
        exRsData_d = IdRsData;
        exRtData_d = IdRtData;
        exImm_d    = IdImm;
        exValid_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exRs_q      <= '0;
      exRt_q      <= '0;
      exRd_q      <= '0;
      exCtrl_q    <= '0;
      exRsData_q  <= '0;
      exRtData_q  <= '0;
      exImm_q     <= '0;
      exValid_q   <= 1'b0;
      bubbleCnt_q <= '0;
    end else begin
      exRs_q      <= exRs_d;
      exRt_q      <= exRt_d;
      exRd_q      <= exRd_d;
      exCtrl_q    <= exCtrl_d;
      exRsData_q  <= exRsData_d;
      exRtData_q  <= exRtData_d;
      exImm_q     <= exImm_d;
      exValid_q   <= exValid_d;
      bubbleCnt_q <= bubbleCnt_d;
    end
  end

  assign IdExRs     = exRs_q;
  assign IdExRt     = exRt_q;
  assign IdExRd     = exRd_q;
  assign IdExCtrl   = exCtrl_q;
  assign IdExRsData = exRsData_q;
  assign IdExRtData = exRtData_q;
  assign IdExImm    = exImm_q;
  assign IdExValid  = exValid_q;
  assign BubbleCnt  = bubbleCnt_q;

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// tb_id_ex_hazard_reg
// Directed bench for id_ex_hazard_reg. A narrow bubble counter is used so
// that saturation at all-ones is reachable in a short run.
module tb_id_ex_hazard_reg;
  import core_pkg::*;

  localparam int DATA_W   = 32;
  localparam int TB_CNT_W = 4;

  localparam ctrl_t CTRL_ADD = ctrl_t'(1 << CTRL_REGW);
  localparam ctrl_t CTRL_LW  = ctrl_t'((1 << CTRL_REGW) | (1 << CTRL_MEMR) |
                                       (1 << CTRL_MEM2REG) | (1 << CTRL_ALUSRC));

  logic                clk;
  logic                rst_n;
  logic                Stall;
  logic                Flush;
  logic [4:0]          IfIdRs;
  logic [4:0]          IfIdRt;
  logic [4:0]          IdRd;
  logic [CTRL_W-1:0]   IdCtrl;
  logic [DATA_W-1:0]   IdRsData;
  logic [DATA_W-1:0]   IdRtData;
  logic [DATA_W-1:0]   IdImm;
  logic [4:0]          IdExRs;
  logic [4:0]          IdExRt;
  logic [4:0]          IdExRd;
  logic [CTRL_W-1:0]   IdExCtrl;
  logic [DATA_W-1:0]   IdExRsData;
  logic [DATA_W-1:0]   IdExRtData;
  logic [DATA_W-1:0]   IdExImm;
  logic                IdExValid;
  logic                HazardStall;
  logic [TB_CNT_W-1:0] BubbleCnt;

  int assertCount = 0;
  int failCount   = 0;

  id_ex_hazard_reg #(
    .DATA_W (DATA_W),
    .CNT_W  (TB_CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .Stall       (Stall),
    .Flush       (Flush),
    .IfIdRs      (IfIdRs),
    .IfIdRt      (IfIdRt),
    .IdRd        (IdRd),
    .IdCtrl      (IdCtrl),
    .IdRsData    (IdRsData),
    .IdRtData    (IdRtData),
    .IdImm       (IdImm),
    .IdExRs      (IdExRs),
    .IdExRt      (IdExRt),
    .IdExRd      (IdExRd),
    .IdExCtrl    (IdExCtrl),
    .IdExRsData  (IdExRsData),
    .IdExRtData  (IdExRtData),
    .IdExImm     (IdExImm),
    .IdExValid   (IdExValid),
    .HazardStall (HazardStall),
    .BubbleCnt   (BubbleCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rd, input ctrl_t ctrl,
                               input logic [DATA_W-1:0] rsData,
                               input logic [DATA_W-1:0] rtData,
                               input logic [DATA_W-1:0] imm,
                               input logic stall, input logic flush);
    IfIdRs   = rs;
    IfIdRt   = rt;
    IdRd     = rd;
    IdCtrl   = ctrl;
    IdRsData = rsData;
    IdRtData = rtData;
    IdImm    = imm;
    Stall    = stall;
    Flush    = flush;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    applyStimulus(5'd0, 5'd0, 5'd0, '0, '0, '0, '0, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #2;
    checkOutput("reset valid", 32'(IdExValid), 32'd0);
    checkOutput("reset cnt", 32'(BubbleCnt), 32'd0);
    checkOutput("reset rs", 32'(IdExRs), 32'd0);
    checkOutput("reset hazard", 32'(HazardStall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] pass-through");
    applyStimulus(5'd3, 5'd4, 5'd7, CTRL_ADD, 32'hAAAA_0001, 32'hBBBB_0002, 32'h10, 1'b0, 1'b0);
    tick();
    checkOutput("pass rs", 32'(IdExRs), 32'd3);
    checkOutput("pass rt", 32'(IdExRt), 32'd4);
    checkOutput("pass rd", 32'(IdExRd), 32'd7);
    checkOutput("pass ctrl", 32'(IdExCtrl), 32'(CTRL_ADD));
    checkOutput("pass rsdata", IdExRsData, 32'hAAAA_0001);
    checkOutput("pass rtdata", IdExRtData, 32'hBBBB_0002);
    checkOutput("pass imm", IdExImm, 32'h10);
    checkOutput("pass valid", 32'(IdExValid), 32'd1);
    checkOutput("pass hazard", 32'(HazardStall), 32'd0);

    $display("[TB] load-use");
    applyStimulus(5'd1, 5'd5, 5'd5, CTRL_LW, 32'h100, 32'h0, 32'h4, 1'b0, 1'b0);
    tick();
    checkOutput("lw rt", 32'(IdExRt), 32'd5);
    applyStimulus(5'd5, 5'd6, 5'd8, CTRL_ADD, 32'h11, 32'h22, 32'h0, 1'b0, 1'b0);
    checkOutput("lu hazard", 32'(HazardStall), 32'd1);
    tick();
    checkOutput("lu bubble ctrl", 32'(IdExCtrl), 32'd0);
    checkOutput("lu bubble rs", 32'(IdExRs), 32'd0);
    checkOutput("lu bubble valid", 32'(IdExValid), 32'd0);
    checkOutput("lu bubble data", IdExRsData, 32'd0);
    checkOutput("lu cnt", 32'(BubbleCnt), 32'd1);
    checkOutput("lu hazard drop", 32'(HazardStall), 32'd0);
    tick();
    checkOutput("lu add rs", 32'(IdExRs), 32'd5);
    checkOutput("lu add rd", 32'(IdExRd), 32'd8);
    checkOutput("lu add valid", 32'(IdExValid), 32'd1);

    $display("[TB] no false stall");
    applyStimulus(5'd2, 5'd0, 5'd0, CTRL_LW, 32'h0, 32'h0, 32'h8, 1'b0, 1'b0);
    tick();
    applyStimulus(5'd0, 5'd0, 5'd3, CTRL_ADD, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    checkOutput("r0 hazard", 32'(HazardStall), 32'd0);
    applyStimulus(5'd9, 5'd9, 5'd9, CTRL_ADD, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    applyStimulus(5'd9, 5'd1, 5'd2, CTRL_ADD, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    checkOutput("nonload hazard", 32'(HazardStall), 32'd0);
    tick();
    checkOutput("nonload valid", 32'(IdExValid), 32'd1);
    checkOutput("nonload cnt", 32'(BubbleCnt), 32'd1);

    $display("[TB] global hold");
    applyStimulus(5'd1, 5'd5, 5'd5, CTRL_LW, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    applyStimulus(5'd2, 5'd5, 5'd10, CTRL_ADD, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("hold hazard", 32'(HazardStall), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("hold rt", 32'(IdExRt), 32'd5);
      checkOutput("hold ctrl", 32'(IdExCtrl), 32'(CTRL_LW));
      checkOutput("hold valid", 32'(IdExValid), 32'd1);
      checkOutput("hold cnt", 32'(BubbleCnt), 32'd1);
      checkOutput("hold hazard", 32'(HazardStall), 32'd1);
    end
    applyStimulus(5'd2, 5'd5, 5'd10, CTRL_ADD, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    checkOutput("release valid", 32'(IdExValid), 32'd0);
    checkOutput("release cnt", 32'(BubbleCnt), 32'd2);
    tick();
    checkOutput("release rd", 32'(IdExRd), 32'd10);
    checkOutput("release cnt2", 32'(BubbleCnt), 32'd2);

    $display("[TB] flush vs hazard");
    applyStimulus(5'd1, 5'd5, 5'd5, CTRL_LW, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    applyStimulus(5'd5, 5'd6, 5'd7, CTRL_ADD, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    checkOutput("flush hazard", 32'(HazardStall), 32'd0);
    tick();
    checkOutput("flush valid", 32'(IdExValid), 32'd0);
    checkOutput("flush ctrl", 32'(IdExCtrl), 32'd0);
    checkOutput("flush cnt", 32'(BubbleCnt), 32'd2);
    applyStimulus(5'd11, 5'd12, 5'd13, CTRL_ADD, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    checkOutput("post flush rs", 32'(IdExRs), 32'd11);

    $display("[TB] saturation");
    applyStimulus(5'd5, 5'd5, 5'd5, CTRL_LW, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 13; i++) begin
      tick();
      tick();
    end
    checkOutput("sat reach", 32'(BubbleCnt), 32'hF);
    tick();
    checkOutput("sat hazard", 32'(HazardStall), 32'd1);
    tick();
    checkOutput("sat bubble", 32'(IdExValid), 32'd0);
    checkOutput("sat hold", 32'(BubbleCnt), 32'hF);

    $display("[TB] async reset mid-stream");
    applyStimulus(5'd3, 5'd4, 5'd7, CTRL_ADD, 32'h55, 32'h66, 32'h77, 1'b0, 1'b0);
    tick();
    checkOutput("pre reset valid", 32'(IdExValid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async valid", 32'(IdExValid), 32'd0);
    checkOutput("async rs", 32'(IdExRs), 32'd0);
    checkOutput("async ctrl", 32'(IdExCtrl), 32'd0);
    checkOutput("async data", IdExRsData, 32'd0);
    checkOutput("async cnt", 32'(BubbleCnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checkOutput("after reset rs", 32'(IdExRs), 32'd3);
    checkOutput("after reset valid", 32'(IdExValid), 32'd1);
    checkOutput("after reset cnt", 32'(BubbleCnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
